vproc_elem_seq: RTL and testbench

- Sequencer in front of the ELEM unit. Accepts one ELEM instruction descriptor at a time and expands it into the per-beat control stream the ELEM pipeline consumes: first/last beat flags, vl-tail flags, element index and gather sub-beat count.
- Handles VRGATHER sub-beat expansion and the FLUSH tail after VCOMPRESS.
- Sits between the vector decode/dispatch stage and the ELEM operand-fetch stage.

---
 rtl/vproc_elem_seq.sv | 178 +++++++++++++++++
 tb/tb_vproc_elem_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_elem_seq.sv
// ELEM-unit sequencer: expands one ELEM instruction descriptor into the per-beat
// control stream (first/last, vl tail, element index, gather sub-beat, compress flush).
package vproc_pkg;
  typedef enum logic [3:0] {
    ELEM_XMV       = 4'd0,
    ELEM_VPOPC     = 4'd1,
    ELEM_VFIRST    = 4'd2,
    ELEM_VID       = 4'd3,
    ELEM_VIOTA     = 4'd4,
    ELEM_VRGATHER  = 4'd5,
    ELEM_VCOMPRESS = 4'd6,
    ELEM_FLUSH     = 4'd7,
    ELEM_VREDSUM   = 4'd8,
    ELEM_VREDAND   = 4'd9,
    ELEM_VREDOR    = 4'd10,
    ELEM_VREDXOR   = 4'd11,
    ELEM_VREDMINU  = 4'd12,
    ELEM_VREDMIN   = 4'd13,
    ELEM_VREDMAXU  = 4'd14,
    ELEM_VREDMAX   = 4'd15
  } op_elem_t;
endpackage

module vproc_elem_seq
  import vproc_pkg::*;
#(
  parameter int unsigned VREG_W      = 128,
  parameter int unsigned GATHER_OP_W = 32,
  parameter int unsigned IDX_W       = $clog2(VREG_W),
  parameter int unsigned AUX_W       = $clog2(VREG_W / GATHER_OP_W)
) (
  input  logic             clk_i,
  input  logic             async_rst_ni,
  input  logic             kill_i,

  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  op_elem_t         instr_op_i,
  input  logic [1:0]       instr_eew_i,
  input  logic [1:0]       instr_emul_i,
  input  logic [31:0]      instr_vl_i,
  input  logic             instr_masked_i,
  input  logic             instr_xreg_i,
  input  logic [4:0]       instr_res_vaddr_i,

  output logic             beat_valid_o,
  input  logic             beat_ready_i,
  output op_elem_t         beat_op_o,
  output logic [1:0]       beat_eew_o,
  output logic [1:0]       beat_emul_o,
  output logic             beat_masked_o,
  output logic             beat_xreg_o,
  output logic [4:0]       beat_res_vaddr_o,
  output logic             beat_first_cycle_o,
  output logic             beat_last_cycle_o,
  output logic             beat_vl_part_0_o,
  output logic             beat_vl_0_o,
  output logic [IDX_W-1:0] beat_elem_idx_o,
  output logic [AUX_W-1:0] beat_aux_count_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    op_elem_t         op;
    logic [1:0]       eew;
    logic [1:0]       emul;
    logic [31:0]      vl;
    logic             masked;
    logic             xreg;
    logic [4:0]       res_vaddr;
    logic [IDX_W-1:0] vlmax_m1;
  } desc_t;

  state_t           state_q, state_d;
  desc_t            desc_q, desc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [AUX_W-1:0] aux_q, aux_d;

  logic [31:0] vlmax_new;
  logic        is_gather;
  logic        final_beat;
  logic        to_flush;
  logic        beat_hs;
  logic        last_beat;
  logic        accept;

  // VLMAX - 1 fits IDX_W bits even at the largest configuration (VLMAX = VREG_W).
  assign vlmax_new = (32'(VREG_W / 8) >> instr_eew_i) << instr_emul_i;

  assign is_gather  = (state_q == RUN) && (desc_q.op == ELEM_VRGATHER);
  assign final_beat = (idx_q == desc_q.vlmax_m1) && (!is_gather || (aux_q == '1));
  assign to_flush   = (state_q == RUN) && (desc_q.op == ELEM_VCOMPRESS);

  assign beat_valid_o  = (state_q != IDLE);
  assign beat_hs       = beat_valid_o && beat_ready_i;
  assign last_beat     = beat_valid_o && final_beat && !to_flush;
  assign instr_ready_o = !kill_i && ((state_q == IDLE) || (last_beat && beat_ready_i));
  assign accept        = instr_valid_i && instr_ready_o;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    desc_d  = desc_q;
    idx_d   = idx_q;
    aux_d   = aux_q;

    if (kill_i) begin
      state_d = IDLE;
    end else begin
      if (beat_hs) begin
        if (final_beat) begin
          idx_d   = '0;
          aux_d   = '0;
          state_d = to_flush ? FLUSH : IDLE;
        end else if (is_gather) begin
          aux_d = aux_q + AUX_W'(1);
          if (aux_q == '1) begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      // A same-cycle accept overrides the return to IDLE above.
      if (accept) begin
        desc_d.op        = instr_op_i;
        desc_d.eew       = instr_eew_i;
        desc_d.emul      = instr_emul_i;
        desc_d.vl        = instr_vl_i;
        desc_d.masked    = instr_masked_i;
        desc_d.xreg      = instr_xreg_i;
        desc_d.res_vaddr = instr_res_vaddr_i;
        desc_d.vlmax_m1  = IDX_W'(vlmax_new - 32'd1);
        idx_d            = '0;
        aux_d            = '0;
        state_d          = RUN;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q <= IDLE;
      desc_q  <= '0;
      idx_q   <= '0;
      aux_q   <= '0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      idx_q   <= idx_d;
      aux_q   <= aux_d;
    end
  end

  assign beat_op_o          = (state_q == FLUSH) ? ELEM_FLUSH : desc_q.op;
  assign beat_eew_o         = desc_q.eew;
  assign beat_emul_o        = desc_q.emul;
  assign beat_masked_o      = desc_q.masked;
  assign beat_xreg_o        = desc_q.xreg;
  assign beat_res_vaddr_o   = desc_q.res_vaddr;
  assign beat_first_cycle_o = (state_q == RUN) && (idx_q == '0) && (aux_q == '0);
  assign beat_last_cycle_o  = last_beat;
  // Tail flags are gated by valid so that the reset/idle state reports all zeros.
  assign beat_vl_part_0_o   = beat_valid_o && (32'(idx_q) >= desc_q.vl);
  assign beat_vl_0_o        = beat_valid_o && (desc_q.vl == 32'd0);
  assign beat_elem_idx_o    = idx_q;
  assign beat_aux_count_o   = aux_q;
  assign busy_o             = beat_valid_o;

endmodule

// File: tb/tb_vproc_elem_seq.sv
// Bench for vproc_elem_seq: a per-instruction beat list built from the expansion
// rules is compared beat by beat against the DUT under random backpressure.
module tb_vproc_elem_seq;
  import vproc_pkg::*;

  localparam int VREG_W      = 128;
  localparam int GATHER_OP_W = 32;
  localparam int IDX_W       = $clog2(VREG_W);
  localparam int AUX_W       = $clog2(VREG_W / GATHER_OP_W);
  localparam int LIMIT       = 4000;

  logic             clk_i = 1'b0;
  logic             async_rst_ni = 1'b0;
  logic             kill_i = 1'b0;
  logic             instr_valid_i = 1'b0;
  logic             instr_ready_o;
  op_elem_t         instr_op_i = ELEM_XMV;
  logic [1:0]       instr_eew_i = '0;
  logic [1:0]       instr_emul_i = '0;
  logic [31:0]      instr_vl_i = '0;
  logic             instr_masked_i = 1'b0;
  logic             instr_xreg_i = 1'b0;
  logic [4:0]       instr_res_vaddr_i = '0;
  logic             beat_valid_o;
  logic             beat_ready_i = 1'b0;
  op_elem_t         beat_op_o;
  logic [1:0]       beat_eew_o, beat_emul_o;
  logic             beat_masked_o, beat_xreg_o;
  logic [4:0]       beat_res_vaddr_o;
  logic             beat_first_cycle_o, beat_last_cycle_o;
  logic             beat_vl_part_0_o, beat_vl_0_o;
  logic [IDX_W-1:0] beat_elem_idx_o;
  logic [AUX_W-1:0] beat_aux_count_o;
  logic             busy_o;

  vproc_elem_seq #(.VREG_W(VREG_W), .GATHER_OP_W(GATHER_OP_W)) dut (
    .clk_i             (clk_i),
    .async_rst_ni      (async_rst_ni),
    .kill_i            (kill_i),
    .instr_valid_i     (instr_valid_i),
    .instr_ready_o     (instr_ready_o),
    .instr_op_i        (instr_op_i),
    .instr_eew_i       (instr_eew_i),
    .instr_emul_i      (instr_emul_i),
    .instr_vl_i        (instr_vl_i),
    .instr_masked_i    (instr_masked_i),
    .instr_xreg_i      (instr_xreg_i),
    .instr_res_vaddr_i (instr_res_vaddr_i),
    .beat_valid_o      (beat_valid_o),
    .beat_ready_i      (beat_ready_i),
    .beat_op_o         (beat_op_o),
    .beat_eew_o        (beat_eew_o),
    .beat_emul_o       (beat_emul_o),
    .beat_masked_o     (beat_masked_o),
    .beat_xreg_o       (beat_xreg_o),
    .beat_res_vaddr_o  (beat_res_vaddr_o),
    .beat_first_cycle_o(beat_first_cycle_o),
    .beat_last_cycle_o (beat_last_cycle_o),
    .beat_vl_part_0_o  (beat_vl_part_0_o),
    .beat_vl_0_o       (beat_vl_0_o),
    .beat_elem_idx_o   (beat_elem_idx_o),
    .beat_aux_count_o  (beat_aux_count_o),
    .busy_o            (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    op_elem_t    op;
    logic [1:0]  eew;
    logic [1:0]  emul;
    logic [31:0] vl;
    logic        masked;
    logic        xreg;
    logic [4:0]  vaddr;
  } desc_t;

  typedef struct packed {
    op_elem_t         op;
    logic             first;
    logic             last;
    logic             vlp;
    logic             vl0;
    logic [IDX_W-1:0] idx;
    logic [AUX_W-1:0] aux;
    logic [1:0]       eew;
    logic [1:0]       emul;
    logic             masked;
    logic             xreg;
    logic [4:0]       vaddr;
    logic             rdy;
  } beat_t;

  typedef struct {
    desc_t d;
    int    stall_pct;
    int    exp_beats;
    int    exp_tail;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic desc_t mk(input op_elem_t op, input int eew, input int emul, input int vl);
    desc_t d;
    d.op     = op;
    d.eew    = 2'(eew);
    d.emul   = 2'(emul);
    d.vl     = 32'(vl);
    d.masked = 1'b1;
    d.xreg   = 1'b0;
    d.vaddr  = 5'(3 + eew + 4 * emul);
    return d;
  endfunction

  // Expected beats for one instruction: every element, gather sub-beats, then the compress flush pass.
  task automatic model_push(input desc_t d);
    int    vlmax;
    int    subs;
    bit    cmp;
    beat_t b;
    vlmax = ((VREG_W / 8) >> d.eew) << d.emul;
    subs  = (d.op == ELEM_VRGATHER) ? VREG_W / GATHER_OP_W : 1;
    cmp   = (d.op == ELEM_VCOMPRESS);
    b = '0;
    b.eew = d.eew; b.emul = d.emul; b.masked = d.masked; b.xreg = d.xreg; b.vaddr = d.vaddr;
    b.vl0 = (d.vl == 0);
    for (int e = 0; e < vlmax; e++) begin
      for (int s = 0; s < subs; s++) begin
        b.op    = d.op;
        b.first = (e == 0 && s == 0);
        b.last  = !cmp && e == vlmax - 1 && s == subs - 1;
        b.vlp   = (32'(e) >= d.vl);
        b.idx   = IDX_W'(e);
        b.aux   = AUX_W'(s);
        exp_q.push_back(b);
      end
    end
    if (cmp) begin
      for (int e = 0; e < vlmax; e++) begin
        b.op    = ELEM_FLUSH;
        b.first = 1'b0;
        b.last  = (e == vlmax - 1);
        b.vlp   = (32'(e) >= d.vl);
        b.idx   = IDX_W'(e);
        b.aux   = '0;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic drive(input desc_t d);
    instr_op_i        = d.op;
    instr_eew_i       = d.eew;
    instr_emul_i      = d.emul;
    instr_vl_i        = d.vl;
    instr_masked_i    = d.masked;
    instr_xreg_i      = d.xreg;
    instr_res_vaddr_i = d.vaddr;
    instr_valid_i     = 1'b1;
  endtask

  function automatic beat_t sample();
    beat_t b;
    b.op = beat_op_o; b.first = beat_first_cycle_o; b.last = beat_last_cycle_o;
    b.vlp = beat_vl_part_0_o; b.vl0 = beat_vl_0_o; b.idx = beat_elem_idx_o;
    b.aux = beat_aux_count_o; b.eew = beat_eew_o; b.emul = beat_emul_o;
    b.masked = beat_masked_o; b.xreg = beat_xreg_o; b.vaddr = beat_res_vaddr_o;
    b.rdy = instr_ready_o;
    return b;
  endfunction

  // Issues d (and optionally nxt as soon as d is taken) and consumes beats until the expected list drains.
  task automatic collect(input desc_t d, input int stall_pct, input bit have_next, input desc_t nxt,
                         output int nbeats, output int ntail, output int bubbles);
    int    guard;
    bit    acc_pending;
    bit    next_sent;
    bit    started;
    beat_t obs;
    beat_t expb;
    guard = 0; acc_pending = 0; next_sent = 0; started = 0;
    nbeats = 0; ntail = 0; bubbles = 0;
    model_push(d);
    if (have_next) model_push(nxt);
    @(negedge clk_i);
    drive(d);
    beat_ready_i = 1'b0;
    while (exp_q.size() > 0) begin
      if (guard > 0) begin
        @(negedge clk_i);
        if (acc_pending) begin
          instr_valid_i = 1'b0;
          acc_pending   = 1'b0;
          if (have_next && !next_sent) begin
            drive(nxt);
            next_sent = 1'b1;
          end
        end
        beat_ready_i = ($urandom_range(99) >= stall_pct);
      end
      #1;
      if (instr_valid_i && instr_ready_o) acc_pending = 1'b1;
      if (beat_valid_o) begin
        started  = 1'b1;
        expb     = exp_q[0];
        expb.rdy = expb.last && beat_ready_i;
        obs      = sample();
        check(beat_ready_i ? "beat" : "stall_hold", 64'(obs), 64'(expb));
        if (beat_ready_i) begin
          void'(exp_q.pop_front());
          nbeats++;
          if (obs.vlp) ntail++;
        end
      end else if (started) begin
        bubbles++;
      end
      guard++;
      if (guard > LIMIT) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: %0d beats still outstanding after %0d cycles", exp_q.size(), guard);
        exp_q.delete();
      end
    end
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    beat_ready_i  = 1'b0;
    #1;
    check("idle_after", {busy_o, beat_valid_o, instr_ready_o}, 3'b001);
  endtask

  vec_t  vecs[$];
  vec_t  v;
  desc_t d, d2;
  int    nb, nt, bub, vlmax;

  initial begin
    // Reset values: everything low except instr_ready_o.
    #1;
    check("rst_ready", instr_ready_o, 1'b1);
    check("rst_beat", {beat_valid_o, busy_o, beat_first_cycle_o, beat_last_cycle_o, beat_vl_part_0_o,
                       beat_vl_0_o, beat_elem_idx_o, beat_aux_count_o, beat_op_o}, '0);
    check("rst_desc", {beat_eew_o, beat_emul_o, beat_masked_o, beat_xreg_o, beat_res_vaddr_o}, '0);
    repeat (2) @(negedge clk_i);
    async_rst_ni = 1'b1;

    // Kill at element 2 with a new descriptor offered in the same cycle.
    @(negedge clk_i);
    drive(mk(ELEM_VREDSUM, 0, 0, 16));
    beat_ready_i = 1'b1;
    #1 check("kill_acc_ready", instr_ready_o, 1'b1);
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1 check("kill_at_idx", {beat_valid_o, beat_elem_idx_o}, {1'b1, IDX_W'(2)});
    drive(mk(ELEM_VID, 1, 0, 4));
    kill_i = 1'b1;
    #1 check("kill_blocks_ready", instr_ready_o, 1'b0);
    @(negedge clk_i);
    kill_i        = 1'b0;
    instr_valid_i = 1'b0;
    #1 check("kill_idle", {beat_valid_o, busy_o, instr_ready_o}, 3'b001);
    @(negedge clk_i);
    #1 check("kill_no_accept", busy_o, 1'b0);

    // Asynchronous reset while in the compress flush phase.
    @(negedge clk_i);
    drive(mk(ELEM_VCOMPRESS, 0, 0, 5));
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    for (int i = 0; i < 100 && beat_op_o != ELEM_FLUSH; i++) @(negedge clk_i);
    #1 check("reach_flush", beat_op_o, ELEM_FLUSH);
    async_rst_ni = 1'b0;
    #1;
    check("arst_flags", {beat_valid_o, busy_o, instr_ready_o, beat_last_cycle_o, beat_vl_part_0_o,
                         beat_elem_idx_o, beat_op_o}, {3'b001, 2'b00, IDX_W'(0), ELEM_XMV});
    @(negedge clk_i);
    async_rst_ni = 1'b1;
    beat_ready_i = 1'b0;

    // Directed vectors: expected beat and tail counts come from hand-derived VLMAX arithmetic.
    vecs.push_back('{mk(ELEM_VREDSUM,   2, 0, 3),   0,   4,  1});
    vecs.push_back('{mk(ELEM_VRGATHER,  2, 0, 4),   0,  16,  0});
    vecs.push_back('{mk(ELEM_VCOMPRESS, 0, 1, 20),  0,  64, 24});
    vecs.push_back('{mk(ELEM_VREDMAX,   0, 0, 0),   0,  16, 16});
    vecs.push_back('{mk(ELEM_VREDSUM,   2, 0, 3),  50,   4,  1});
    vecs.push_back('{mk(ELEM_VID,       1, 2, 100), 40, 32,  0});
    vecs.push_back('{mk(ELEM_VREDOR,    0, 3, 128), 20, 128, 0});
    vecs.push_back('{mk(ELEM_VRGATHER,  1, 0, 2),  50,  32, 24});
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      collect(v.d, v.stall_pct, 1'b0, v.d, nb, nt, bub);
      check($sformatf("vec%0d_beats", i), 64'(nb), 64'(v.exp_beats));
      check($sformatf("vec%0d_tail", i), 64'(nt), 64'(v.exp_tail));
    end

    // Back-to-back: second descriptor is taken on the first one's last beat, no bubble in between.
    collect(mk(ELEM_VREDSUM, 2, 0, 4), 30, 1'b1, mk(ELEM_VRGATHER, 2, 0, 3), nb, nt, bub);
    check("b2b_beats", 64'(nb), 64'(4 + 16));
    check("b2b_bubbles", 64'(bub), 64'(0));

    // Random descriptors and backpressure against the beat-list model.
    for (int i = 0; i < 30; i++) begin
      int r;
      r        = $urandom_range(14);
      d.op     = op_elem_t'(4'(r >= 7 ? r + 1 : r));
      d.eew    = 2'($urandom_range(2));
      d.emul   = 2'($urandom_range(3));
      vlmax    = ((VREG_W / 8) >> d.eew) << d.emul;
      case ($urandom_range(3))
        0:       d.vl = 32'd0;
        1:       d.vl = $urandom;
        default: d.vl = 32'($urandom_range(vlmax + 2));
      endcase
      d.masked = 1'($urandom_range(1));
      d.xreg   = 1'($urandom_range(1));
      d.vaddr  = 5'($urandom_range(31));
      if ($urandom_range(1) == 1) begin
        d2 = mk(ELEM_VREDXOR, int'($urandom_range(2)), 0, int'($urandom_range(8)));
        collect(d, int'($urandom_range(60)), 1'b1, d2, nb, nt, bub);
        check($sformatf("rnd%0d_bubbles", i), 64'(bub), 64'(0));
      end else begin
        collect(d, int'($urandom_range(60)), 1'b0, d, nb, nt, bub);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
